output_port_demux: RTL and testbench
====================================

Name: output_port_demux

Overview:
- Downstream neighbour of the packet-processing pipeline. Consumes the pipeline's egress stream (134-bit packet words plus a per-packet valid flag) and buffers it.
- Steers each accepted packet to one of NUM_PORTS physical transmit queues, using the output-port field in the packet's first (metadata) word.
- Discards packets whose valid flag is 0 or whose port is out of range, and counts them.

Parameters:
- NUM_PORTS, 8: number of transmit ports (1..16).
- PKT_FIFO_AW, 8: address width of the word FIFO (depth 256 words).
- VLD_FIFO_AW, 6: address width of the valid-flag FIFO (depth 64 entries).
- AF_MARGIN, 32: free-word count at or below which almostfull asserts.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low.
- in_outputctrl_pkt_wr  in  1  word write strobe.
- in_outputctrl_pkt  in  134  word: [133:132] flag (01 head, 11 middle, 10 tail), [131:128] invalid-byte count, [127:0] data.
- in_outputctrl_valid_wr  in  1  per-packet flag strobe, issued with or after the tail word.
- in_outputctrl_valid  in  1  1 = forward, 0 = discard.
- out_outputctrl_pkt_almostfull  out  1  backpressure to upstream.
- out_port_pkt_wr  out  NUM_PORTS  one-hot word strobe.
- out_port_pkt  out  134  shared word bus.
- out_port_valid_wr  out  NUM_PORTS  one-hot flag strobe.
- out_port_valid  out  1  always 1 when strobed.
- in_port_pkt_almostfull  in  NUM_PORTS  per-port backpressure.
- out_drop_cnt  out  32  discarded-packet count.
- out_ovf_err  out  1  sticky overflow error.

Behaviour:
- Reset values: all strobes 0, out_port_pkt 0, out_port_valid 0, out_drop_cnt 0, out_ovf_err 0, almostfull 0, FSM in IDLE, both FIFOs empty.
- Buffering:
  - Word FIFO and flag FIFO are written independently.
  - almostfull = (word free ≤ AF_MARGIN) OR (flag free ≤ 4). It is registered, so 1 cycle late.
  - A write to a full FIFO is dropped and sets out_ovf_err, which clears only on reset.
- FIFO read is non-showahead: data is valid 1 cycle after rd.
- FSM:
  - IDLE: when the flag FIFO is non-empty, pop the flag and pop word 0, then go to HEAD.
  - HEAD: word 0 is now available and is latched into a holding register.
    - port = word0[115:112].
    - If flag = 0 or port ≥ NUM_PORTS: out_drop_cnt +1, go to DISCARD.
    - Otherwise go to WAIT.
  - WAIT: stay while in_port_pkt_almostfull[port] = 1. When it is 0, drive the held word with out_port_pkt_wr[port] = 1, pop the next word, and go to SEND.
  - SEND: each cycle, present the popped word with pkt_wr[port], and pop again unless that word is the tail.
    - On the tail word, also assert out_port_valid_wr[port] = 1 and out_port_valid = 1 in the same cycle, then go to IDLE.
    - Per-port almostfull is checked only in WAIT; a packet is never paused mid-stream.
  - DISCARD: pop words, emit nothing, return to IDLE on the tail.
- Single-word packet: a word with flag 10 in HEAD is treated as head and tail together. It is sent in one cycle, or discarded.
- A word with flag 01 arriving in SEND or DISCARD is treated as a tail (truncation); the next packet resynchronises.
- Throughput: one word per cycle in SEND; 2 idle cycles between packets (IDLE, HEAD).
- Latency from first word written (with flag already present) to first output word: 4 cycles, given an idle port.
- out_drop_cnt wraps modulo 2^32.
- A simultaneous FIFO write and read is legal, including when the FIFO is full with a read in the same cycle: no overflow is flagged.
- The word FIFO must never underflow: the flag precedes only complete packets. If it is empty anyway, the FSM stalls in place.

Decomposition:
- Shared package:
  - flag encodings: HEAD 2'b01, MID 2'b11, TAIL 2'b10
  - the port-field bit positions 115:112
  - FSM state enum: IDLE, HEAD, WAIT, SEND, DISCARD
- One sub-module: opd_sync_fifo (parameterised width/depth, registered read data, full/empty/free-count). Instantiated twice: 134-bit words and 1-bit flags.

Test Plan:
- Forward: one 4-word packet, port=3, valid=1 → 4 strobes on pkt_wr[3] with words in order; valid_wr[3] on the 4th word; other ports silent; drop_cnt=0.
- Discard: a 3-word packet with valid=0, then a 2-word packet to port 0 → the first is silent and drop_cnt=1; the second appears on port 0 without corruption.
- Range: port=9 with NUM_PORTS=8 → dropped, drop_cnt=1.
- Per-port backpressure: in_port_pkt_almostfull[5]=1 for 20 cycles, packet to port 5 → no strobes during the hold; the full packet starts on the 1st cycle after release.
- Backpressure and overflow:
  - Write 230 words without reads (port held almostfull) → almostfull asserts once free ≤ 32.
  - Continue writing to 257 words → out_ovf_err=1, sticky until reset.
- Reset mid-SEND: assert reset during word 2 of 6 → all outputs 0 immediately; after release the FIFOs are empty, the FSM is in IDLE, and the next packet passes intact.

Source files
------------

// File: rtl/output_port_demux_pkg.sv
// Shared definitions for the output port demultiplexer: word layout,
// flag encodings, port-field position and the steering FSM states.
package output_port_demux_pkg;

    localparam int PKT_W    = 134;
    localparam int PORT_MSB = 115;
    localparam int PORT_LSB = 112;
    localparam int PORT_W   = PORT_MSB - PORT_LSB + 1;

    localparam logic [1:0] FLAG_HEAD = 2'b01;
    localparam logic [1:0] FLAG_MID  = 2'b11;
    localparam logic [1:0] FLAG_TAIL = 2'b10;

    // One egress word: position flag, invalid-byte count, payload.
    typedef struct packed {
        logic [1:0]   flag;
        logic [3:0]   inv;
        logic [127:0] data;
    } pkt_word_t;

    typedef enum logic [2:0] {
        IDLE,
        HEAD,
        WAIT,
        SEND,
        DISCARD
    } state_t;

    // A word closes the current packet if it is a tail, or if a new head
    // shows up mid-packet (truncated packet: resynchronise on it).
    function automatic logic ends_pkt(input logic [1:0] flag);
        return (flag == FLAG_TAIL) || (flag == FLAG_HEAD);
    endfunction

endpackage

// File: rtl/opd_sync_fifo.sv
// Synchronous FIFO with registered (non-showahead) read data: rdata is
// valid the cycle after rd. Writes to a full FIFO are ignored unless a
// read happens in the same cycle.
module opd_sync_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic [W-1:0]  wdata,
    input  logic          rd,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   free
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;
    logic          rd_ok;
    logic          wr_ok;

    assign empty = (cnt == '0);
    assign full  = (cnt == (AW+1)'(DEPTH));
    assign free  = (AW+1)'(DEPTH) - cnt;
    assign rd_ok = rd && !empty;
    assign wr_ok = wr && (!full || rd_ok);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (wr_ok) wp <= wp + 1'b1;
            if (rd_ok) rp <= rp + 1'b1;
            if (wr_ok && !rd_ok)      cnt <= cnt + 1'b1;
            else if (rd_ok && !wr_ok) cnt <= cnt - 1'b1;
        end
    end

    // Storage array, no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wp] <= wdata;
    end

    // Registered read port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     rdata <= '0;
        else if (rd_ok) rdata <= mem[rp];
    end

endmodule

// File: rtl/output_port_demux.sv
// Buffers the pipeline egress stream and steers each packet to one of
// NUM_PORTS transmit queues by the port field of its metadata word.
// Packets flagged invalid or addressed out of range are counted and dropped.
module output_port_demux
    import output_port_demux_pkg::*;
#(
    parameter int NUM_PORTS   = 8,
    parameter int PKT_FIFO_AW = 8,
    parameter int VLD_FIFO_AW = 6,
    parameter int AF_MARGIN   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_outputctrl_pkt_wr,
    input  logic [PKT_W-1:0]     in_outputctrl_pkt,
    input  logic                 in_outputctrl_valid_wr,
    input  logic                 in_outputctrl_valid,
    output logic                 out_outputctrl_pkt_almostfull,
    output logic [NUM_PORTS-1:0] out_port_pkt_wr,
    output logic [PKT_W-1:0]     out_port_pkt,
    output logic [NUM_PORTS-1:0] out_port_valid_wr,
    output logic                 out_port_valid,
    input  logic [NUM_PORTS-1:0] in_port_pkt_almostfull,
    output logic [31:0]          out_drop_cnt,
    output logic                 out_ovf_err
);

    localparam logic [PORT_W:0] NUM_PORTS_W = (PORT_W+1)'(NUM_PORTS);

    // FIFO interfaces
    logic [PKT_W-1:0]     word_q;
    logic                 word_rd;
    logic                 word_full;
    logic                 word_empty;
    logic [PKT_FIFO_AW:0] word_free;
    logic [0:0]           flag_q;
    logic                 flag_rd;
    logic                 flag_full;
    logic                 flag_empty;
    logic [VLD_FIFO_AW:0] flag_free;

    // Steering state
    state_t                state;
    state_t                state_nx;
    pkt_word_t             cur;
    pkt_word_t             hold;
    logic                  hold_tail;
    logic [PORT_W-1:0]     port_q;
    logic [NUM_PORTS-1:0]  port_oh;
    logic                  port_ok;
    logic                  wait_af;
    logic                  rvld;

    // Per-cycle actions decided by the FSM
    logic                  emit;
    logic                  emit_last;
    pkt_word_t             emit_word;
    logic                  latch;
    logic                  drop_inc;

    opd_sync_fifo #(.W(PKT_W), .AW(PKT_FIFO_AW)) u_word_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (in_outputctrl_pkt_wr),
        .wdata (in_outputctrl_pkt),
        .rd    (word_rd),
        .rdata (word_q),
        .full  (word_full),
        .empty (word_empty),
        .free  (word_free)
    );

    opd_sync_fifo #(.W(1), .AW(VLD_FIFO_AW)) u_flag_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (in_outputctrl_valid_wr),
        .wdata (in_outputctrl_valid),
        .rd    (flag_rd),
        .rdata (flag_q),
        .full  (flag_full),
        .empty (flag_empty),
        .free  (flag_free)
    );

    assign cur     = pkt_word_t'(word_q);
    assign port_ok = ({1'b0, cur.data[PORT_MSB:PORT_LSB]} < NUM_PORTS_W);
    assign wait_af = |(in_port_pkt_almostfull & port_oh);

    // One-hot decode of the latched destination port.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            port_oh[i] = (port_q == PORT_W'(i));
        end
    end

    // Steering FSM: state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Steering FSM: next state, FIFO pops and emit decisions.
    // Pops are always gated by FIFO occupancy so an unexpectedly empty
    // word FIFO just stalls the current state.
    always_comb begin
        state_nx  = state;
        word_rd   = 1'b0;
        flag_rd   = 1'b0;
        emit      = 1'b0;
        emit_last = 1'b0;
        emit_word = cur;
        latch     = 1'b0;
        drop_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (!flag_empty && !word_empty) begin
                    flag_rd  = 1'b1;
                    word_rd  = 1'b1;
                    state_nx = HEAD;
                end
            end
            HEAD: begin
                latch = 1'b1;
                if (!flag_q[0] || !port_ok) begin
                    drop_inc = 1'b1;
                    if (cur.flag == FLAG_TAIL) begin
                        state_nx = IDLE;
                    end else begin
                        word_rd  = !word_empty;
                        state_nx = DISCARD;
                    end
                end else begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (!wait_af) begin
                    emit      = 1'b1;
                    emit_word = hold;
                    if (hold_tail) begin
                        emit_last = 1'b1;
                        state_nx  = IDLE;
                    end else begin
                        word_rd  = !word_empty;
                        state_nx = SEND;
                    end
                end
            end
            SEND: begin
                if (rvld) begin
                    emit = 1'b1;
                    if (ends_pkt(cur.flag)) begin
                        emit_last = 1'b1;
                        state_nx  = IDLE;
                    end else begin
                        word_rd = !word_empty;
                    end
                end else begin
                    word_rd = !word_empty;
                end
            end
            DISCARD: begin
                if (rvld && ends_pkt(cur.flag)) state_nx = IDLE;
                else                            word_rd  = !word_empty;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Tracks whether word_q holds a word popped last cycle and not yet used.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rvld <= 1'b0;
        else        rvld <= word_rd && !word_empty;
    end

    // Holding register for the metadata word while the port is checked.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold      <= '0;
            hold_tail <= 1'b0;
            port_q    <= '0;
        end else if (latch) begin
            hold      <= cur;
            hold_tail <= (cur.flag == FLAG_TAIL);
            port_q    <= cur.data[PORT_MSB:PORT_LSB];
        end
    end

    // Registered transmit-side outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_port_pkt_wr   <= '0;
            out_port_valid_wr <= '0;
            out_port_valid    <= 1'b0;
            out_port_pkt      <= '0;
        end else begin
            out_port_pkt_wr   <= emit ? port_oh : '0;
            out_port_valid_wr <= emit_last ? port_oh : '0;
            out_port_valid    <= emit_last;
            if (emit) out_port_pkt <= emit_word;
        end
    end

    // Drop counter, sticky overflow flag and upstream backpressure.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_drop_cnt                  <= '0;
            out_ovf_err                   <= 1'b0;
            out_outputctrl_pkt_almostfull <= 1'b0;
        end else begin
            if (drop_inc) out_drop_cnt <= out_drop_cnt + 32'd1;
            if ((in_outputctrl_pkt_wr && word_full && !word_rd) ||
                (in_outputctrl_valid_wr && flag_full && !flag_rd))
                out_ovf_err <= 1'b1;
            out_outputctrl_pkt_almostfull <=
                (word_free <= (PKT_FIFO_AW+1)'(AF_MARGIN)) ||
                (flag_free <= (VLD_FIFO_AW+1)'(4));
        end
    end

endmodule

// File: tb/tb_output_port_demux.sv
// Randomised bench for output_port_demux with a packet-level reference model.
module tb_output_port_demux;

    localparam int NP = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pkt_wr = 1'b0;
    logic [133:0]  pkt = '0;
    logic          vwr = 1'b0;
    logic          vld = 1'b0;
    logic          af;
    logic [NP-1:0] o_wr;
    logic [133:0]  o_pkt;
    logic [NP-1:0] o_vwr;
    logic          o_v;
    logic [NP-1:0] port_af = '0;
    logic [31:0]   drop;
    logic          ovf;

    int total = 0;
    int bad = 0;
    int exp_drop = 0;

    typedef struct packed {
        logic [NP-1:0] wr;
        logic [NP-1:0] vwr;
        logic          v;
        logic [133:0]  w;
    } ent_t;

    ent_t exp_q[$];
    ent_t obs_q[$];

    always #5 clk = ~clk;

    output_port_demux dut (
        .clk                           (clk),
        .reset                         (rst_n),
        .in_outputctrl_pkt_wr          (pkt_wr),
        .in_outputctrl_pkt             (pkt),
        .in_outputctrl_valid_wr        (vwr),
        .in_outputctrl_valid           (vld),
        .out_outputctrl_pkt_almostfull (af),
        .out_port_pkt_wr               (o_wr),
        .out_port_pkt                  (o_pkt),
        .out_port_valid_wr             (o_vwr),
        .out_port_valid                (o_v),
        .in_port_pkt_almostfull        (port_af),
        .out_drop_cnt                  (drop),
        .out_ovf_err                   (ovf)
    );

    // Record every cycle that carries any transmit strobe.
    always @(negedge clk) begin
        if (rst_n && ((|o_wr) || (|o_vwr))) obs_q.push_back({o_wr, o_vwr, o_v, o_pkt});
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Write one packet; the model keeps what should appear on the ports.
    task automatic send_pkt(input int port, input int len, input bit v);
        for (int i = 0; i < len; i++) begin
            logic [133:0] w;
            logic [1:0]   f;
            logic [NP-1:0] oh;
            bit last;
            last = (i == len - 1);
            f = last ? 2'b10 : (i == 0) ? 2'b01 : 2'b11;
            w[127:0]   = {$urandom, $urandom, $urandom, $urandom};
            w[131:128] = 4'($urandom_range(0, 15));
            w[133:132] = f;
            if (i == 0) w[115:112] = 4'(port);
            oh = (port < NP) ? NP'(1) << port : '0;
            if (v && port < NP) exp_q.push_back({oh, last ? oh : NP'(0), last, w});
            else if (last) exp_drop++;
            @(negedge clk);
            pkt_wr = 1'b1;
            pkt    = w;
            vwr    = last;
            vld    = v;
        end
        @(negedge clk);
        pkt_wr = 1'b0;
        vwr    = 1'b0;
        vld    = 1'b0;
    endtask

    // Wait for the expected number of output words, then a few quiet cycles.
    task automatic drain(input int budget, output bit ok);
        int n = 0;
        while (obs_q.size() < exp_q.size() && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        repeat (8) @(negedge clk);
        #1;
        ok = (n < budget);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        total++; if (o_wr !== '0)   begin bad++; $display("FAIL reset_pkt_wr got=%h want=0", o_wr); end
        total++; if (o_vwr !== '0)  begin bad++; $display("FAIL reset_valid_wr got=%h want=0", o_vwr); end
        total++; if (o_pkt !== '0)  begin bad++; $display("FAIL reset_pkt got=%h want=0", o_pkt); end
        total++; if (o_v !== 1'b0)  begin bad++; $display("FAIL reset_valid got=%b want=0", o_v); end
        total++; if (drop !== 32'd0) begin bad++; $display("FAIL reset_drop got=%0d want=0", drop); end
        total++; if (ovf !== 1'b0)  begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
        total++; if (af !== 1'b0)   begin bad++; $display("FAIL reset_af got=%b want=0", af); end
    endtask

    task automatic test_forward();
        bit ok;
        send_pkt(3, 4, 1'b1);
        drain(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL fwd_timeout got=%0d words want=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL fwd_word%0d got=%h want=%h", i, (i < obs_q.size()) ? obs_q[i] : ent_t'(0), exp_q[i]);
            end
        end
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL fwd_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        total++; if (drop !== 32'(exp_drop)) begin bad++; $display("FAIL fwd_drop got=%0d want=%0d", drop, exp_drop); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_discard();
        bit ok;
        send_pkt(1, 3, 1'b0);
        send_pkt(0, 2, 1'b1);
        drain(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL disc_timeout got=%0d words want=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL disc_word%0d got=%h want=%h", i, (i < obs_q.size()) ? obs_q[i] : ent_t'(0), exp_q[i]);
            end
        end
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL disc_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        total++; if (drop !== 32'(exp_drop)) begin bad++; $display("FAIL disc_drop got=%0d want=%0d", drop, exp_drop); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_range();
        send_pkt(9, 3, 1'b1);
        repeat (20) @(negedge clk);
        #1;
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL range_silent got=%0d words want=0", obs_q.size()); end
        total++; if (drop !== 32'(exp_drop)) begin bad++; $display("FAIL range_drop got=%0d want=%0d", drop, exp_drop); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_port_backpressure();
        bit ok;
        port_af[5] = 1'b1;
        send_pkt(5, 3, 1'b1);
        repeat (20) @(negedge clk);
        #1;
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL bp_hold got=%0d words want=0", obs_q.size()); end
        port_af[5] = 1'b0;
        @(negedge clk);
        #1;
        total++; if (obs_q.size() != 1) begin bad++; $display("FAIL bp_start got=%0d words want=1", obs_q.size()); end
        drain(100, ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_timeout got=%0d words want=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL bp_word%0d got=%h want=%h", i, (i < obs_q.size()) ? obs_q[i] : ent_t'(0), exp_q[i]);
            end
        end
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL bp_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        bit ok;
        for (int p = 0; p < 16; p++) begin
            send_pkt($urandom_range(0, 9), $urandom_range(1, 6), $urandom_range(0, 9) != 0);
        end
        drain(1000, ok);
        total++; if (!ok) begin bad++; $display("FAIL rnd_timeout got=%0d words want=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL rnd_word%0d got=%h want=%h", i, (i < obs_q.size()) ? obs_q[i] : ent_t'(0), exp_q[i]);
            end
        end
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        total++; if (drop !== 32'(exp_drop)) begin bad++; $display("FAIL rnd_drop got=%0d want=%0d", drop, exp_drop); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_send();
        bit ok;
        int n = 0;
        port_af[2] = 1'b1;
        send_pkt(2, 6, 1'b1);
        repeat (4) @(negedge clk);
        port_af[2] = 1'b0;
        while (obs_q.size() < 2 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++; if (obs_q.size() != 2) begin bad++; $display("FAIL rst_mid_reach got=%0d words want=2", obs_q.size()); end
        rst_n = 1'b0;
        #1;
        total++; if (o_wr !== '0)  begin bad++; $display("FAIL rst_mid_pkt_wr got=%h want=0", o_wr); end
        total++; if (o_pkt !== '0) begin bad++; $display("FAIL rst_mid_pkt got=%h want=0", o_pkt); end
        total++; if (o_vwr !== '0 || o_v !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%h/%b want=0/0", o_vwr, o_v); end
        obs_q.delete(); exp_q.delete();
        exp_drop = 0;
        @(negedge clk);
        rst_n = 1'b1;
        send_pkt(2, 3, 1'b1);
        drain(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL rst_mid_timeout got=%0d words want=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL rst_mid_word%0d got=%h want=%h", i, (i < obs_q.size()) ? obs_q[i] : ent_t'(0), exp_q[i]);
            end
        end
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rst_mid_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        total++; if (drop !== 32'(exp_drop)) begin bad++; $display("FAIL rst_mid_drop got=%0d want=%0d", drop, exp_drop); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_overflow();
        int words = 0;
        int targets[4] = '{223, 224, 256, 257};
        for (int t = 0; t < 4; t++) begin
            while (words < targets[t]) begin
                @(negedge clk);
                pkt_wr = 1'b1;
                pkt    = {2'b11, 4'd0, $urandom, $urandom, $urandom, $urandom};
                words++;
            end
            @(negedge clk);
            pkt_wr = 1'b0;
            repeat (2) @(negedge clk);
            #1;
            total++;
            if (af !== ((256 - (words > 256 ? 256 : words)) <= 32)) begin
                bad++; $display("FAIL ovf_af@%0d got=%b want=%b", words, af, (256 - (words > 256 ? 256 : words)) <= 32);
            end
            total++;
            if (ovf !== (words > 256)) begin
                bad++; $display("FAIL ovf_err@%0d got=%b want=%b", words, ovf, words > 256);
            end
        end
        repeat (10) @(negedge clk);
        #1;
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", ovf); end
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL ovf_silent got=%0d words want=0", obs_q.size()); end
        rst_n = 1'b0;
        #1;
        total++; if (ovf !== 1'b0 || af !== 1'b0) begin bad++; $display("FAIL ovf_reset got=%b/%b want=0/0", ovf, af); end
        @(negedge clk);
        rst_n = 1'b1;
        obs_q.delete(); exp_q.delete();
        exp_drop = 0;
    endtask

    task automatic test_single_word();
        bit ok;
        send_pkt(1, 1, 1'b1);
        send_pkt(4, 1, 1'b0);
        send_pkt(7, 1, 1'b1);
        drain(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_timeout got=%0d words want=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL single_word%0d got=%h want=%h", i, (i < obs_q.size()) ? obs_q[i] : ent_t'(0), exp_q[i]);
            end
        end
        total++; if (drop !== 32'(exp_drop)) begin bad++; $display("FAIL single_drop got=%0d want=%0d", drop, exp_drop); end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_forward();
        test_discard();
        test_range();
        test_port_backpressure();
        test_random();
        test_reset_mid_send();
        test_overflow();
        test_single_word();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
